pulse_shape_filt: RTL and testbench

Parametrised, time-multiplexed symmetric FIR for the 4-ASK link. It replaces the fixed-length transmit and matched-receive filters with one block that selects TX pulse-shaping or RCV matched coefficients by a mode input. It runs one shared multiplier over OSR system clocks per input sample, driven by a sample strobe. It sits between the symbol mapper and the DAC path on TX, and between the ADC path and the slicer on RCV.

---
 rtl/pulse_shape_pkg.sv | 43 ++++
 rtl/pulse_shape_filt_coef.sv | 57 +++++
 rtl/pulse_shape_filt.sv | 130 +++++++++++++
 tb/tb_pulse_shape_filt.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_shape_pkg.sv
// Shared types, default coefficient tables and output rounding for pulse_shape_filt.
// Used by both build variants (PULSE_SHAPE_COEF_LOAD_EN defined or not).
package pulse_shape_pkg;

   localparam int unsigned DEF_W  = 18;
   localparam int unsigned DEF_CW = 18;
   localparam int unsigned COEF_W = 18;

   typedef logic signed [COEF_W-1:0] coef_t;

   // Half-filter taps, index 10 is the centre of the default 21-tap response
   localparam coef_t TX_COEF [32] = '{
      -18'sd1200, -18'sd2600, 18'sd1900, 18'sd6400, 18'sd3100, -18'sd9800,
      -18'sd14500, 18'sd8200, 18'sd36000, 18'sd62000, 18'sd75000,
      18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0,
      18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0
   };

   localparam coef_t RCV_COEF [32] = '{
      18'sd800, -18'sd1500, -18'sd3300, 18'sd2700, 18'sd9100, 18'sd4200,
      -18'sd12600, -18'sd7000, 18'sd29000, 18'sd58000, 18'sd70000,
      18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0,
      18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0
   };

   typedef enum logic [1:0] {IDLE, MAC, ROUND} state_e;

   // Round-half-up from Q(cw-1) products back to the sample scale, then clamp to w bits
   function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                    input int unsigned     w,
                                                    input int unsigned     cw);
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r  = (acc + (64'sd1 <<< (cw - 2))) >>> (cw - 1);
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (r > hi)      return hi;
      else if (r < lo) return lo;
      else             return r;
   endfunction

endpackage

// File: rtl/pulse_shape_filt_coef.sv
// Coefficient store for pulse_shape_filt: constant ROM, or a loadable 2-set bank
// with per-pass snapshot when PULSE_SHAPE_COEF_LOAD_EN is defined.
module pulse_shape_coef
   import pulse_shape_pkg::*;
#(
   parameter int unsigned HALF = 11,
   parameter int unsigned CW   = DEF_CW
) (
`ifdef PULSE_SHAPE_COEF_LOAD_EN
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          snap_i,
   input  logic          we_i,
   input  logic [5:0]    addr_i,
   input  logic [CW-1:0] data_i,
`endif
   input  logic          mode_q_i,
   input  logic [4:0]    k_i,
   output logic [CW-1:0] coef_o
);

`ifdef PULSE_SHAPE_COEF_LOAD_EN
   logic [1:0][31:0][CW-1:0] def_bank;
   logic [1:0][31:0][CW-1:0] bank_q;
   logic [1:0][31:0][CW-1:0] snap_q;

   for (genvar g = 0; g < 32; g++) begin : g_def
      assign def_bank[0][g] = (g < HALF) ? CW'(TX_COEF[g]) : '0;
      assign def_bank[1][g] = (g < HALF) ? CW'(RCV_COEF[g]) : '0;
   end

   // The MAC reads the snapshot so writes never disturb a pass in flight
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         bank_q <= def_bank;
         snap_q <= def_bank;
      end else begin
         if (we_i && (32'(addr_i[4:0]) < HALF)) begin
            bank_q[addr_i[5]][addr_i[4:0]] <= data_i;
         end
         if (snap_i) begin
            snap_q <= bank_q;
         end
      end
   end

   assign coef_o = snap_q[mode_q_i][k_i];
`else
   always_comb begin
      coef_o = '0;
      if (32'(k_i) < HALF) begin
         coef_o = mode_q_i ? CW'(RCV_COEF[k_i]) : CW'(TX_COEF[k_i]);
      end
   end
`endif

endmodule

// File: rtl/pulse_shape_filt.sv
// Time-multiplexed symmetric FIR (TX shaping / RCV matched) with one shared multiplier.
// Optional coefficient write port: PULSE_SHAPE_COEF_LOAD_EN.
module pulse_shape_filt
   import pulse_shape_pkg::*;
#(
   parameter int unsigned TAPS = 21,
   parameter int unsigned OSR  = 16,
   parameter int unsigned W    = DEF_W,
   parameter int unsigned CW   = DEF_CW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          sam_en,
   input  logic [W-1:0]  x_in,
   input  logic          mode,
   output logic [W-1:0]  y,
   output logic          y_valid,
   output logic          busy,
   output logic          overrun
`ifdef PULSE_SHAPE_COEF_LOAD_EN
   ,
   input  logic          coef_we,
   input  logic [5:0]    coef_addr,
   input  logic [CW-1:0] coef_data
`endif
);

   localparam int unsigned HALF = (TAPS + 1) / 2;
   localparam int unsigned KW   = $clog2(TAPS);
   localparam int unsigned AW   = W + 1 + CW + $clog2(HALF);

   if ((TAPS % 2 == 0) || (TAPS < 3) || (TAPS > 63)) begin : g_bad_taps
      $error("pulse_shape_filt: TAPS must be odd and within 3..63");
   end
   if (OSR < HALF + 2) begin : g_bad_osr
      $error("pulse_shape_filt: OSR too small for one MAC pass per sample");
   end

   state_e                 state_q;
   logic [TAPS-1:0][W-1:0] x_q;
   logic [KW-1:0]          k_q;
   logic signed [AW-1:0]   acc_q;
   logic signed [AW-1:0]   acc_d;
   logic                   mode_q;
   logic [W-1:0]           y_q;
   logic [W-1:0]           y_d;
   logic                   y_valid_q;
   logic                   busy_q;
   logic                   overrun_q;

   logic                   accept;
   logic signed [W-1:0]    xa;
   logic signed [W-1:0]    xb;
   logic signed [W:0]      p;
   logic [CW-1:0]          coef;
   logic signed [W+CW:0]   prod;

   pulse_shape_coef #(.HALF(HALF), .CW(CW)) u_coef (
`ifdef PULSE_SHAPE_COEF_LOAD_EN
      .clk_i    (clk),
      .rst_ni   (reset),
      .snap_i   (accept),
      .we_i     (coef_we),
      .addr_i   (coef_addr),
      .data_i   (coef_data),
`endif
      .mode_q_i (mode_q),
      .k_i      (5'(k_q)),
      .coef_o   (coef)
   );

   // Fold mirrored taps before the multiply; the centre tap has no partner
   always_comb begin
      accept = sam_en && (state_q == IDLE);
      xa     = $signed(x_q[k_q]);
      xb     = $signed(x_q[KW'(TAPS - 1) - k_q]);
      if (k_q == KW'(HALF - 1)) p = {xa[W-1], xa};
      else                      p = {xa[W-1], xa} + {xb[W-1], xb};
      prod   = p * $signed(coef);
      acc_d  = acc_q + AW'(prod);
      y_d    = W'(round_sat(64'(acc_q), W, CW));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         x_q       <= '0;
         k_q       <= '0;
         acc_q     <= '0;
         mode_q    <= 1'b0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         y_valid_q <= 1'b0;
         if (sam_en && (state_q != IDLE)) overrun_q <= 1'b1;
         unique case (state_q)
            IDLE: begin
               if (sam_en) begin
                  x_q     <= {x_q[TAPS-2:0], x_in};
                  mode_q  <= mode;
                  acc_q   <= '0;
                  k_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= MAC;
               end
            end
            MAC: begin
               acc_q <= acc_d;
               k_q   <= k_q + KW'(1);
               if (k_q == KW'(HALF - 1)) state_q <= ROUND;
            end
            ROUND: begin
               y_q       <= y_d;
               y_valid_q <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign y       = y_q;
   assign y_valid = y_valid_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_pulse_shape_filt.sv
// Self-checking bench for pulse_shape_filt: impulse tables, saturation, overrun,
// reset corners and random samples against a direct-form convolution model.
module tb_pulse_shape_filt;

   localparam int TAPS = 21;
   localparam int HALF = 11;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               sam_en = 1'b0;
   logic               mode = 1'b0;
   logic signed [17:0] x_in = '0;
   logic [17:0]        y;
   logic               y_valid;
   logic               busy;
   logic               overrun;
`ifdef PULSE_SHAPE_COEF_LOAD_EN
   logic               coef_we = 1'b0;
   logic [5:0]         coef_addr = '0;
   logic [17:0]        coef_data = '0;
`endif

   always #5 clk = ~clk;

   pulse_shape_filt #(.TAPS(21), .OSR(16), .W(18), .CW(18)) dut (
      .clk       (clk),
      .reset     (reset),
      .sam_en    (sam_en),
      .x_in      (x_in),
      .mode      (mode),
      .y         (y),
      .y_valid   (y_valid),
      .busy      (busy),
      .overrun   (overrun)
`ifdef PULSE_SHAPE_COEF_LOAD_EN
      ,
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data)
`endif
   );

   localparam longint TX_REF  [HALF] = '{-1200, -2600, 1900, 6400, 3100, -9800, -14500, 8200, 36000, 62000, 75000};
   localparam longint RCV_REF [HALF] = '{800, -1500, -3300, 2700, 9100, 4200, -12600, -7000, 29000, 58000, 70000};
   localparam longint TX_IMP  [TAPS] = '{-1200, -2600, 1900, 6400, 3100, -9800, -14500, 8200, 36000, 62000, 74999,
                                        62000, 36000, 8200, -14500, -9800, 3100, 6400, 1900, -2600, -1200};
   localparam longint RCV_IMP [TAPS] = '{800, -1500, -3300, 2700, 9100, 4200, -12600, -7000, 29000, 58000, 69999,
                                        58000, 29000, -7000, -12600, 4200, 9100, 2700, -3300, -1500, 800};

   typedef struct {
      logic signed [17:0] x;
      logic               m;
      bit                 rst;
      longint             exp_y;
   } vec_t;

   vec_t   tbl[$];
   int     n_cmp = 0;
   int     n_bad = 0;
   longint cm [2][HALF];
   longint hist[$];

   function automatic void check(input string name, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endfunction

   function automatic void model_reset();
      hist = {};
      for (int i = 0; i < TAPS; i++) hist.push_back(0);
      for (int i = 0; i < HALF; i++) begin
         cm[0][i] = TX_REF[i];
         cm[1][i] = RCV_REF[i];
      end
   endfunction

   // y[n] = sum_j h[j]*x[n-j] over the full symmetric response, rounded and clamped
   function automatic longint model_push(input longint x, input logic m);
      longint acc = 0;
      longint r;
      hist.push_front(x);
      void'(hist.pop_back());
      for (int j = 0; j < TAPS; j++) acc += hist[j] * cm[m][(j < HALF) ? j : TAPS - 1 - j];
      r = (acc + 65536) >>> 17;
      if (r > 131071)  r = 131071;
      if (r < -131072) r = -131072;
      return r;
   endfunction

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      model_reset();
   endtask

   task automatic do_sample(input logic signed [17:0] x, input logic m, input longint exp,
                            input int win, input string name, output longint got);
      int nv = 0;
      int lat = -1;
      got    = 0;
      sam_en = 1'b1;
      x_in   = x;
      mode   = m;
      @(posedge clk);
      #1;
      sam_en = 1'b0;
      x_in   = 18'($urandom);
      mode   = ~m;
      for (int n = 1; n <= win; n++) begin
         @(negedge clk);
         if (n == 1) check({name, "_busy"}, longint'(busy), 1);
         if (y_valid) begin
            nv++;
            lat = n;
            got = $signed(y);
         end
      end
      check({name, "_nvalid"}, nv, 1);
      check({name, "_lat"}, lat, 13);
      check({name, "_y"}, got, exp);
   endtask

   task automatic run_table(input int lo, input int hi, input bit allow_rst, input string name);
      longint g;
      for (int i = lo; i < hi; i++) begin
         if (allow_rst && tbl[i].rst) do_reset();
         do_sample(tbl[i].x, tbl[i].m, tbl[i].exp_y, 16, $sformatf("%s%0d", name, i - lo), g);
      end
   endtask

   initial begin
      longint g;
      longint e;
      int     nv;
      logic signed [17:0] xr;
      logic   mr;

      for (int i = 0; i <= TAPS; i++)
         tbl.push_back(vec_t'{(i == 0) ? 18'sd131071 : 18'sd0, 1'b0, i == 0, (i < TAPS) ? TX_IMP[i] : 0});
      for (int i = 0; i <= TAPS; i++)
         tbl.push_back(vec_t'{(i == 0) ? 18'sd131071 : 18'sd0, 1'b1, i == 0, (i < TAPS) ? RCV_IMP[i] : 0});
      model_reset();

      // reset low while a strobe is presented: the sample must be discarded
      reset  = 1'b0;
      sam_en = 1'b1;
      x_in   = 18'sd131071;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      sam_en = 1'b0;
      x_in   = '0;
      @(negedge clk);
      check("rst_y", $signed(y), 0);
      check("rst_yvalid", longint'(y_valid), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_overrun", longint'(overrun), 0);

      run_table(0, TAPS + 1, 1'b0, "tx_imp");
      run_table(TAPS + 1, 2 * TAPS + 2, 1'b1, "rcv_imp");

      // sustained worst case, both polarities
      do_reset();
      for (int i = 0; i < TAPS; i++) begin
         xr = (TX_REF[(i < HALF) ? i : TAPS - 1 - i] > 0) ? 18'sd131071 : -18'sd131071;
         e  = model_push(xr, 1'b0);
         do_sample(xr, 1'b0, e, 16, $sformatf("satp%0d", i), g);
      end
      check("sat_pos_clamp", g, 131071);
      for (int i = 0; i < TAPS; i++) begin
         xr = (TX_REF[(i < HALF) ? i : TAPS - 1 - i] > 0) ? -18'sd131072 : 18'sd131071;
         e  = model_push(xr, 1'b0);
         do_sample(xr, 1'b0, e, 16, $sformatf("satn%0d", i), g);
      end
      check("sat_neg_clamp", g, -131072);

      // reset in the middle of a MAC pass
      @(negedge clk);
      sam_en = 1'b1;
      x_in   = 18'sd131071;
      @(posedge clk);
      #1 sam_en = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      model_reset();
      @(negedge clk);
      check("midrst_y", $signed(y), 0);
      check("midrst_busy", longint'(busy), 0);
      nv = 0;
      for (int n = 0; n < 16; n++) begin
         if (y_valid) nv++;
         @(negedge clk);
      end
      check("midrst_no_valid", nv, 0);
      run_table(0, TAPS + 1, 1'b0, "tx_imp_again");

      // second strobe 3 clocks into a pass
      do_reset();
      @(negedge clk);
      sam_en = 1'b1;
      x_in   = 18'sd5000;
      mode   = 1'b0;
      e      = model_push(5000, 1'b0);
      @(posedge clk);
      #1 sam_en = 1'b0;
      repeat (2) @(posedge clk);
      #1 sam_en = 1'b1;
      x_in   = 18'sd7000;
      @(posedge clk);
      #1 sam_en = 1'b0;
      nv = 0;
      g  = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (y_valid) begin
            nv++;
            g = $signed(y);
         end
      end
      check("ovr_nvalid", nv, 1);
      check("ovr_y", g, e);
      check("ovr_flag", longint'(overrun), 1);
      e = model_push(0, 1'b0);
      do_sample(18'sd0, 1'b0, e, 16, "ovr_next", g);
      check("ovr_sticky", longint'(overrun), 1);
      do_reset();
      @(negedge clk);
      check("ovr_cleared", longint'(overrun), 0);

      // random samples, random modes, spacing down to the minimum accepted gap
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0:       xr = 18'sd131071;
            1:       xr = -18'sd131072;
            default: xr = 18'($urandom);
         endcase
         mr = 1'($urandom_range(0, 1));
         e  = model_push(xr, mr);
         do_sample(xr, mr, e, $urandom_range(13, 18), $sformatf("rnd%0d", i), g);
      end

`ifdef PULSE_SHAPE_COEF_LOAD_EN
      do_reset();
      @(negedge clk);
      coef_we   = 1'b1;
      coef_addr = 6'd0;
      coef_data = 18'd65536;
      @(posedge clk);
      #1 coef_addr = 6'd20;
      coef_data = 18'd99999;
      @(posedge clk);
      #1 coef_we = 1'b0;
      cm[0][0] = 65536;
      for (int i = 0; i < TAPS; i++) begin
         xr = (i == 0) ? 18'sd131071 : 18'sd0;
         e  = model_push(xr, 1'b0);
         do_sample(xr, 1'b0, e, 16, $sformatf("load%0d", i), g);
         if (i == 0) check("load_first", g, 65536);
      end
      check("load_last", g, 65536);
      do_reset();
      do_sample(18'sd131071, 1'b0, -1200, 16, "load_revert", g);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
